// File: rtl/fft_pkg.sv
// Shared types for the FFT4 output path: complex sample, four-sample group, read FSM states.
package fft_pkg;

    localparam int unsigned DATA_W    = 27;
    localparam int unsigned IDX_W     = 11;
    localparam int unsigned GRP_DEPTH = 4;
    localparam int unsigned PTR_W     = $clog2(GRP_DEPTH);

    typedef struct packed {
        logic signed [DATA_W-1:0] r;
        logic signed [DATA_W-1:0] i;
    } cplx_t;

    typedef struct packed {
        cplx_t [3:0]       s;
        logic [IDX_W-1:0]  idx;
    } grp4_t;

    typedef enum logic {
        StIdle,
        StSerial
    } ser_state_e;

endpackage

// File: rtl/grp_fifo.sv
// Synchronous FIFO of four-sample groups; exposes the head and the entry behind it.
module grp_fifo
    import fft_pkg::*;
#(
    parameter int unsigned DEPTH = GRP_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  grp4_t                    push_data,
    input  logic                     pop,
    output grp4_t                    head,
    output grp4_t                    head_next,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    grp4_t            mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]  level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LvlW'(DEPTH));
    assign do_pop  = pop && (level_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign head      = mem[rd_ptr_q];
    assign head_next = mem[rd_ptr_q + PtrW'(1)];
    assign level     = level_q;

endmodule

// File: rtl/fft4_group_serializer.sv
// Buffers FFT4 result groups and streams them out one complex sample per cycle.
module fft4_group_serializer
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned IDX_WIDTH  = IDX_W,
    parameter int unsigned DEPTH      = GRP_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [IDX_WIDTH-1:0]    in_index,
    input  logic [DATA_WIDTH-1:0]   in0_r,
    input  logic [DATA_WIDTH-1:0]   in0_i,
    input  logic [DATA_WIDTH-1:0]   in1_r,
    input  logic [DATA_WIDTH-1:0]   in1_i,
    input  logic [DATA_WIDTH-1:0]   in2_r,
    input  logic [DATA_WIDTH-1:0]   in2_i,
    input  logic [DATA_WIDTH-1:0]   in3_r,
    input  logic [DATA_WIDTH-1:0]   in3_i,
    input  logic                    out_ready,
    input  logic                    clr_ovf,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_r,
    output logic [DATA_WIDTH-1:0]   out_i,
    output logic [IDX_WIDTH+1:0]    out_index,
    output logic                    full,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    grp4_t                  grp_in, head, head_next, src;
    ser_state_e             state_q, state_d;
    logic [1:0]             k_q, k_d;
    logic [DATA_WIDTH-1:0]  out_r_d, out_i_d;
    logic [IDX_WIDTH+1:0]   out_index_d;
    logic                   overflow_d;
    logic                   pop, drop, load;

    always_comb begin
        grp_in.s[0].r = in0_r;
        grp_in.s[0].i = in0_i;
        grp_in.s[1].r = in1_r;
        grp_in.s[1].i = in1_i;
        grp_in.s[2].r = in2_r;
        grp_in.s[2].i = in2_i;
        grp_in.s[3].r = in3_r;
        grp_in.s[3].i = in3_i;
        grp_in.idx    = in_index;
    end

    assign pop  = (state_q == StSerial) && out_ready && (k_q == 2'd3);
    assign drop = in_valid && full && !pop;

    grp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (grp_in),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .level     (level),
        .full      (full)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        src         = head;
        load        = 1'b0;
        out_r_d     = out_r;
        out_i_d     = out_i;
        out_index_d = out_index;
        unique case (state_q)
            StIdle: begin
                if (level != '0) begin
                    state_d = StSerial;
                    k_d     = 2'd0;
                    load    = 1'b1;
                end
            end
            StSerial: begin
                if (out_ready) begin
                    if (k_q != 2'd3) begin
                        k_d  = k_q + 2'd1;
                        load = 1'b1;
                    end else begin
                        k_d = 2'd0;
                        // Head is being popped; the entry behind it follows without a bubble.
                        if (level > LvlW'(1)) begin
                            src  = head_next;
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            out_r_d     = src.s[k_d].r;
            out_i_d     = src.s[k_d].i;
            out_index_d = {src.idx, k_d};
        end
    end

    always_comb begin
        overflow_d = overflow;
        if (drop)         overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            k_q       <= 2'd0;
            out_r     <= '0;
            out_i     <= '0;
            out_index <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            out_r     <= out_r_d;
            out_i     <= out_i_d;
            out_index <= out_index_d;
            overflow  <= overflow_d;
        end
    end

    assign out_valid = (state_q == StSerial);

endmodule

// File: tb/tb_fft4_group_serializer.sv
// Bench for fft4_group_serializer: directed scenarios plus random traffic against a queue model.
module tb_fft4_group_serializer;

    localparam int DW    = 27;
    localparam int IW    = 11;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0][DW-1:0] r;
        logic [3:0][DW-1:0] i;
        logic [IW-1:0]      idx;
    } grp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [IW-1:0] in_index;
    logic [DW-1:0] in0_r, in0_i, in1_r, in1_i, in2_r, in2_i, in3_r, in3_i;
    logic          out_ready;
    logic          clr_ovf;
    logic          out_valid;
    logic [DW-1:0] out_r, out_i;
    logic [IW+1:0] out_index;
    logic          full;
    logic          overflow;
    logic [2:0]    level;

    int checks = 0;
    int errors = 0;

    // Reference model: stored groups (head first), whether a sample is presented, its k, sticky drop flag.
    grp_t mq[$];
    bit   m_pres;
    int   m_k;
    bit   m_ovf;
    grp_t cur;

    always #5 clk = ~clk;

    fft4_group_serializer #(
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_index  (in_index),
        .in0_r     (in0_r),
        .in0_i     (in0_i),
        .in1_r     (in1_r),
        .in1_i     (in1_i),
        .in2_r     (in2_r),
        .in2_i     (in2_i),
        .in3_r     (in3_r),
        .in3_i     (in3_i),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_index (out_index),
        .full      (full),
        .overflow  (overflow),
        .level     (level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input grp_t g, input logic v);
        cur      = g;
        in_valid = v;
        in_index = g.idx;
        in0_r = g.r[0]; in0_i = g.i[0];
        in1_r = g.r[1]; in1_i = g.i[1];
        in2_r = g.r[2]; in2_i = g.i[2];
        in3_r = g.r[3]; in3_i = g.i[3];
    endtask

    function automatic grp_t rand_grp(input int idx);
        grp_t g;
        for (int k = 0; k < 4; k++) begin
            g.r[k] = DW'($urandom);
            g.i[k] = DW'($urandom);
        end
        g.idx = IW'(idx);
        return g;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pres = 1'b0;
        m_k    = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_outputs();
        logic [IW+1:0] eidx;
        chk("out_valid", out_valid, m_pres);
        chk("level", level, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        if (m_pres && mq.size() > 0) begin
            eidx = {mq[0].idx, m_k[1:0]};
            chk("out_r", out_r, mq[0].r[m_k]);
            chk("out_i", out_i, mq[0].i[m_k]);
            chk("out_index", out_index, eidx);
        end
    endtask

    // Compare current outputs, advance the model with the current inputs, then step one clock.
    task automatic cycle();
        bit xfer, pop, acc;
        int oldsz;
        check_outputs();
        xfer  = m_pres && out_ready;
        pop   = xfer && (m_k == 3);
        oldsz = mq.size();
        acc   = in_valid && (oldsz < DEPTH || pop);
        if (!m_pres) begin
            m_pres = (oldsz > 0);
            m_k    = 0;
        end else if (xfer) begin
            if (m_k < 3) begin
                m_k++;
            end else begin
                m_k    = 0;
                m_pres = (oldsz > 1);
            end
        end
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(cur);
        if (in_valid && !acc) m_ovf = 1'b1;
        else if (clr_ovf)     m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic wait_k(input int k);
        int budget = 20;
        while (!(m_pres && m_k == k) && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) begin
            errors++;
            $display("FAIL wait_k timeout k=%0d", k);
        end
    endtask

    initial begin
        grp_t g;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        g         = '0;
        drive(g, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Single group, idx 5, samples (k+1, -(k+1))
        for (int k = 0; k < 4; k++) begin
            g.r[k] = DW'(k + 1);
            g.i[k] = DW'(-(k + 1));
        end
        g.idx = IW'(5);
        drive(g, 1'b1);
        cycle();
        drive(g, 1'b0);
        idle_cycles(7);
        chk("single_level_end", level, 0);
        chk("single_valid_end", out_valid, 0);

        // Three back-to-back groups
        for (int n = 7; n <= 9; n++) begin
            drive(rand_grp(n), 1'b1);
            cycle();
        end
        drive(cur, 1'b0);
        idle_cycles(15);
        chk("b2b_ovf", overflow, 0);

        // Backpressure mid-group at k=2
        drive(rand_grp(12), 1'b1);
        cycle();
        drive(cur, 1'b0);
        wait_k(2);
        out_ready = 1'b0;
        idle_cycles(5);
        out_ready = 1'b1;
        idle_cycles(6);

        // Overflow: six pushes with the output stalled
        out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            drive(rand_grp(100 + n), 1'b1);
            cycle();
            if (n == 3) chk("ovf_full_after4", full, 1);
        end
        drive(cur, 1'b0);
        chk("ovf_set", overflow, 1);
        out_ready = 1'b1;
        idle_cycles(20);
        chk("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Full FIFO with a push on the cycle the head group pops
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            drive(rand_grp(200 + n), 1'b1);
            cycle();
        end
        drive(cur, 1'b0);
        cycle();
        out_ready = 1'b1;
        wait_k(3);
        drive(rand_grp(300), 1'b1);
        cycle();
        drive(cur, 1'b0);
        chk("simul_level", level, 4);
        chk("simul_ovf", overflow, 0);
        idle_cycles(25);

        // Asynchronous reset while serializing at k=1
        drive(rand_grp(400), 1'b1);
        cycle();
        drive(cur, 1'b0);
        wait_k(1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_r", out_r, 0);
        chk("rst_i", out_i, 0);
        chk("rst_index", out_index, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        drive(rand_grp(401), 1'b1);
        cycle();
        drive(cur, 1'b0);
        idle_cycles(7);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            drive(rand_grp($urandom_range(0, 2047)), ($urandom_range(0, 99) < 35));
            out_ready = ($urandom_range(0, 99) < 70);
            clr_ovf   = ($urandom_range(0, 99) < 5);
            cycle();
        end
        drive(cur, 1'b0);
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        idle_cycles(25);
        chk("final_level", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
